// File: rtl/fifo_thresh.sv
// fifo_thresh -- synchronous show-ahead FIFO with occupancy thresholds.
//
// Purpose:
//   Single-clock FIFO of DEPTH words (any DEPTH >= 2, not only powers of
//   two). rd_data always shows the head entry (first-word fall-through).
//   The registered occupancy counter drives full/empty and the
//   almost_full/almost_empty threshold flags.
//
// Parameters:
//   DATA_WIDTH  data word width (default 16)
//   DEPTH       number of entries (default 8)
//   AF_THRESH   almost_full when level >= AF_THRESH (default DEPTH-2)
//   AE_THRESH   almost_empty when level <= AE_THRESH (default 2)
//   LW          level width, $clog2(DEPTH+1)
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active-high
//   wr_en/wr_data push request and data
//   rd_en/rd_data pop request and head entry (show-ahead)
//   flush         discard all entries (priority over push/pop)
//   clr_err       clears the sticky error flags
//   full, empty, almost_full, almost_empty, level   occupancy status
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
//
// Configuration macro:
//   FIFO_ERR_FLAGS_EN  when defined, overflow/underflow are sticky
//                      registers; otherwise they are tied to 0 and
//                      clr_err is ignored.

module fifo_thresh #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;

    logic w_push;
    logic w_pop;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    // Status is decoded from the registered level only.
    assign full         = (r_level == LW'(DEPTH));
    assign empty        = (r_level == '0);
    assign almost_full  = (r_level >= LW'(AF_THRESH));
    assign almost_empty = (r_level <= LW'(AE_THRESH));
    assign level        = r_level;

    // Gating on full/empty makes push-at-full and pop-at-empty resolve to
    // the single legal operation when both requests arrive together.
    assign w_push = wr_en && !full  && !flush;
    assign w_pop  = rd_en && !empty && !flush;

    assign rd_data = r_mem[r_rd_ptr];

    // Storage has no reset; stale words are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Set is written after clear so a same-cycle error keeps the flag high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            if (wr_en && full)
                r_overflow <= 1'b1;
            if (rd_en && empty)
                r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_err;
    assign overflow     = 1'b0;
    assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_thresh.sv
module tb_fifo_thresh;

    localparam int D    = 5;
    localparam int AF   = 4;
    localparam int AE   = 1;
    localparam int DW   = 16;
    localparam int LW   = $clog2(D + 1);
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic          full, empty, almost_full, almost_empty;
    logic [LW-1:0] level;
    logic          overflow, underflow;

    int n_vec = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    // Reference model: a plain queue plus two sticky bits.
    logic [DW-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    fifo_thresh #(
        .DATA_WIDTH(DW),
        .DEPTH(D),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .flush(flush),
        .clr_err(clr_err),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .level(level),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge, from the block's behavioural rules.
    always @(posedge clk) begin
        int sz;
        bit was_full, was_empty;
        sz        = q.size();
        was_full  = (sz == D);
        was_empty = (sz == 0);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (ERR_EN) begin
                if (clr_err) begin
                    m_ovf = 1'b0;
                    m_unf = 1'b0;
                end
                if (wr_en && was_full)  m_ovf = 1'b1;
                if (rd_en && was_empty) m_unf = 1'b1;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (rd_en && !was_empty) void'(q.pop_front());
                if (wr_en && !was_full)  q.push_back(wr_data);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int sz;
        if (armed) begin
            sz = q.size();
            chk("level",        32'(level),        32'(sz));
            chk("full",         32'(full),         32'(sz == D));
            chk("empty",        32'(empty),        32'(sz == 0));
            chk("almost_full",  32'(almost_full),  32'(sz >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_unf));
            if (sz > 0)
                chk("rd_data", 32'(rd_data), 32'(q[0]));
        end
    end

    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f, input bit c, input bit rs);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        rst     = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        bit w, r, f, c, rs;
        // reset and reset-state literals
        cyc(0, '0, 0, 0, 0, 1);
        armed = 1'b1;
        cyc(0, '0, 0, 0, 0, 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // single word round trip
        cyc(1, 16'hA001, 0, 0, 0, 0);
        chk("rt_data", 32'(rd_data), 32'hA001);
        chk("rt_level1", 32'(level), 1);
        chk("rt_empty0", 32'(empty), 0);
        cyc(0, '0, 1, 0, 0, 0);
        chk("rt_level0", 32'(level), 0);
        chk("rt_empty1", 32'(empty), 1);

        // fill to full and beyond
        for (int k = 1; k <= D; k++) begin
            cyc(1, DW'(16'h0010 + k - 1), 0, 0, 0, 0);
            chk("fill_level", 32'(level), 32'(k));
            chk("fill_ae", 32'(almost_empty), 32'(k <= 1));
            chk("fill_af", 32'(almost_full), 32'(k >= 4));
            chk("fill_full", 32'(full), 32'(k == 5));
        end
        cyc(1, 16'hDEAD, 0, 0, 0, 0);
        chk("ovf_level", 32'(level), 5);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_flag", 32'(overflow), 32'(ERR_EN));
        chk("ovf_head", 32'(rd_data), 32'h0010);
        cyc(0, '0, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(overflow), 32'(ERR_EN));

        // push and pop together while full: only the pop happens
        cyc(1, 16'hBEEF, 1, 0, 0, 0);
        chk("fullrw_level", 32'(level), 4);
        chk("fullrw_full", 32'(full), 0);
        chk("fullrw_head", 32'(rd_data), 32'h0011);

        // clear error flags
        cyc(0, '0, 0, 0, 1, 0);
        chk("clr_ovf", 32'(overflow), 0);

        // flush with simultaneous push and pop
        cyc(1, 16'h1234, 1, 1, 0, 0);
        chk("flush_level", 32'(level), 0);
        chk("flush_empty", 32'(empty), 1);

        // push and pop together while empty: only the push happens
        cyc(1, 16'h55AA, 1, 0, 0, 0);
        chk("emptyrw_level", 32'(level), 1);
        chk("emptyrw_data", 32'(rd_data), 32'h55AA);
        chk("unf_flag", 32'(underflow), 32'(ERR_EN));
        cyc(0, '0, 1, 0, 0, 0);

        // fill 3, flush, then push 0x55AA
        for (int k = 0; k < 3; k++) cyc(1, DW'(16'h0100 + k), 0, 0, 0, 0);
        chk("f3_level", 32'(level), 3);
        cyc(1, 16'hFFFF, 1, 1, 0, 0);
        chk("f3_flush_level", 32'(level), 0);
        chk("f3_flush_empty", 32'(empty), 1);
        cyc(1, 16'h55AA, 0, 0, 0, 0);
        chk("f3_readback", 32'(rd_data), 32'h55AA);

        // reset drops entries and both flags
        cyc(1, 16'h7777, 1, 0, 1, 1);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_unf", 32'(underflow), 0);
        chk("midrst_ovf", 32'(overflow), 0);

        // ordering across pointer wraps: 3 x (push 3, pop 3)
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) cyc(1, DW'(3 * k + j), 0, 0, 0, 0);
            for (int j = 0; j < 3; j++) begin
                chk("wrap_order", 32'(rd_data), 32'(3 * k + j));
                cyc(0, '0, 1, 0, 0, 0);
            end
        end
        chk("wrap_empty", 32'(empty), 1);

        // randomized traffic with drifting push/pop bias
        pw = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) pw = (pw == 80) ? 20 : 80;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < (100 - pw));
            f  = ($urandom_range(0, 59) == 0);
            c  = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 299) == 0);
            cyc(w, DW'($urandom), r, f, c, rs);
        end

        cyc(0, '0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_thresh.md
FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_WIDTH SHALL default to 16 and set the data word width.
REQ-003 Parameter DEPTH SHALL default to 8 and set the number of entries, any integer >= 2 (not restricted to powers of two).
REQ-004 Parameter AF_THRESH SHALL default to DEPTH-2 and set the almost-full level, legal range 1..DEPTH.
REQ-005 Parameter AE_THRESH SHALL default to 2 and set the almost-empty level, legal range 0..DEPTH-1.
REQ-006 LW SHALL be $clog2(DEPTH+1).
REQ-007 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push data.
- rd_en  in  1  pop request.
- rd_data  out  DATA_WIDTH  head entry, show-ahead.
- flush  in  1  synchronous discard of all entries.
- clr_err  in  1  clears the sticky error flags.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  LW  current occupancy.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Function
REQ-008 A push SHALL be accepted in a cycle iff wr_en=1, full=0 and flush=0; the accepted word is written at the write pointer on the rising edge.
REQ-009 A pop SHALL be accepted in a cycle iff rd_en=1, empty=0 and flush=0; the read pointer advances on the rising edge.
REQ-010 rd_data SHALL combinationally present the entry at the read pointer, with zero-cycle latency; its value is don't-care while empty=1.
REQ-011 A word pushed at edge N SHALL be visible on rd_data, with empty=0, after edge N (first-word fall-through, one-cycle write-to-read latency).
REQ-012 Both pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-013 level SHALL be a registered counter updated per edge:
- +1 on push only.
- -1 on pop only.
- unchanged on simultaneous push and pop, or on neither.
REQ-014 full, empty, almost_full and almost_empty SHALL be decoded combinationally from the registered level only.
REQ-015 Simultaneous wr_en and rd_en while full SHALL accept the pop only; the push is rejected.
REQ-016 Simultaneous wr_en and rd_en while empty SHALL accept the push only; the pop is rejected.
REQ-017 flush=1 SHALL take priority over push and pop: pointers and level go to 0 on the edge, and memory contents are not cleared.
REQ-018 Data order SHALL be strictly first-in first-out across any number of pointer wraps.

Reset
REQ-019 With rst=1 on an edge, the block SHALL reset as follows:
- pointers and level go to 0.
- overflow and underflow go to 0.
- after the edge, empty=1, full=0, almost_empty=1, and almost_full=(AF_THRESH==0 ? 1 : 0).
REQ-020 rst SHALL override flush, push, pop and clr_err in the same cycle.
REQ-021 Reset asserted mid-operation SHALL discard all held entries; memory SHALL need no reset.

Configuration
REQ-022 With macro FIFO_ERR_FLAGS_EN defined:
- overflow SHALL set on any edge where wr_en=1 and full=1.
- underflow SHALL set on any edge where rd_en=1 and empty=1.
- both flags SHALL hold until clr_err=1 or rst=1.
- a set condition in the same cycle as clr_err=1 SHALL win, so the flag stays 1.
REQ-023 Without FIFO_ERR_FLAGS_EN, the overflow and underflow ports SHALL remain present and be tied to 0, no error registers SHALL be inferred, and clr_err SHALL be ignored.

Verification
REQ-024 Reset, then push 0xA001, pop on the next cycle -> rd_data=0xA001 one cycle after the push, level goes 0->1->0, empty=1 at the end.
REQ-025 DEPTH=5, AF_THRESH=4, AE_THRESH=1: push 5 words -> almost_empty drops at level 2, almost_full rises at level 4, full at level 5; a 6th push is rejected and level stays 5.
REQ-026 DEPTH=5: loop 3x (push 3, pop 3) with values 0..8 -> popped sequence 0..8 in order across pointer wraps.
REQ-027 At full (DEPTH=8), assert wr_en and rd_en together -> one pop, the push is rejected, level becomes 7, full=0; at empty with both asserted -> level becomes 1, rd_data equals the written word.
REQ-028 Fill with 3 words, then pulse flush together with wr_en and rd_en -> level=0, empty=1; the next push of 0x55AA is read back as 0x55AA.
REQ-029 With FIFO_ERR_FLAGS_EN defined, assert wr_en while full -> overflow=1 and sticky; pulse clr_err -> 0; assert rd_en while empty -> underflow=1; assert rst -> both 0. Without the macro, both flags are always 0.
